calc_data_stack: RTL

CALC_DATA_STACK -- requirements
Module: calc_data_stack

---
 rtl/calc_data_stack_pkg.sv | 8 +
 rtl/calc_stack_ram.sv | 29 ++
 rtl/calc_data_stack.sv | 104 ++++++++++
 3 files changed

// File: rtl/calc_data_stack_pkg.sv
// Shared calculator operand definitions used by the data stack and its storage.
// CD_N / CD_0 carry the values of the CPU_INTERNAL operand width and zero constant.
package calc_data_stack_pkg;

  localparam int unsigned CD_N = 16;
  localparam logic [CD_N-1:0] CD_0 = '0;

endpackage

// File: rtl/calc_stack_ram.sv
// Operand storage for the calculator data stack: one synchronous write port,
// one asynchronous read port, no reset on the contents.
module calc_stack_ram
  import calc_data_stack_pkg::*;
#(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = CD_N
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned ENTRIES = 2 ** AW;

  logic [DW-1:0] mem_q [ENTRIES];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/calc_data_stack.sv
// Calculator operand stack: count, sticky overflow/underflow flags and command
// priority (clear > push+pop > push > pop); storage lives in calc_stack_ram.
module calc_data_stack
  import calc_data_stack_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            dt_push,
  input  logic [CD_N-1:0] dt_wdata,
  input  logic            dt_pop,
  input  logic            dt_clear,
  output logic [CD_N-1:0] dt_data,
  output logic            dt_empty,
  output logic            dt_full,
  output logic [AW:0]     dt_count,
  output logic            dt_ovf,
  output logic            dt_unf
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [AW-1:0]   top_idx;
  logic [CD_N-1:0] rdata;
  logic            empty;
  logic            full;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign top_idx = AW'(count_q - 1'b1);

  // Command decode; clear overrides everything, push+pop on empty acts as push.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    waddr   = AW'(count_q);
    if (dt_clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (dt_push && dt_pop) begin
      we = 1'b1;
      if (!empty) begin
        waddr = top_idx;
      end else begin
        count_d = (AW+1)'(count_q + 1'b1);
      end
    end else if (dt_push) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        we      = 1'b1;
        count_d = (AW+1)'(count_q + 1'b1);
      end
    end else if (dt_pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        count_d = (AW+1)'(count_q - 1'b1);
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  calc_stack_ram #(
    .AW (AW),
    .DW (CD_N)
  ) u_ram (
    .clk_i   (Clock),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (dt_wdata),
    .raddr_i (top_idx),
    .rdata_o (rdata)
  );

  assign dt_data  = empty ? CD_0 : rdata;
  assign dt_empty = empty;
  assign dt_full  = full;
  assign dt_count = count_q;
  assign dt_ovf   = ovf_q;
  assign dt_unf   = unf_q;

endmodule
